// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // Signed variants treat operands as two's complement.
  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Divide ops share the upper op bit.
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift next dividend bit into the remainder, trial-subtract.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < divisor keeps shifted < divisor + 2^WIDTH, so bit WIDTH of diff is a clean borrow.
  // With a zero divisor both arms carry the same low bits, so the remainder ends up as the dividend.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply and restoring divide with HI/LO result registers.
// Latency: WIDTH cycles busy, done pulses the cycle after the final edge (MDU_FAST_MUL_EN: multiply done next cycle).
// Backpressure: start and move-to-HI/LO writes are ignored while busy; no queuing.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;       // negate product / quotient
  logic             rneg_q, rneg_d;     // negate remainder (dividend sign)
  logic             dz_q, dz_d;         // divide by zero
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d; // running product upper / partial remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d; // multiplier bits / dividend bits becoming quotient
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] div_rem;
  logic             div_q;
  logic             mul_c;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes and signs at launch.
  always_comb begin
    a_neg = is_signed_op(op_i) & a_i[WIDTH-1];
    b_neg = is_signed_op(op_i) & b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_hi_q),
    .bit_i     (acc_lo_q[WIDTH-1]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .q_o       (div_q)
  );

  // One iteration of either shift-add multiply or restoring divide.
  always_comb begin
    {mul_c, mul_sum} = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    if (is_div_q) begin
      step_hi = div_rem;
      step_lo = {acc_lo_q[WIDTH-2:0], div_q};
    end else begin
      step_hi = {mul_c, mul_sum[WIDTH-1:1]};
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final iteration's result.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = dz_q ? {WIDTH{1'b1}} : (neg_q ? -step_lo : step_lo);
    rem_fix  = rneg_q ? -step_hi : step_hi;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  // Sign- or zero-extend to full width so one multiplier serves both MULT and MULTU.
  assign fast_prod = {{WIDTH{a_neg}}, a_i} * {{WIDTH{b_neg}}, b_i};
`endif

  // Next-state: FSM, iteration datapath and HI/LO updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef MDU_FAST_MUL_EN
          if (!is_div_op(op_i)) begin
            hi_d   = fast_prod[2*WIDTH-1:WIDTH];
            lo_d   = fast_prod[WIDTH-1:0];
            done_d = 1'b1;
          end else
`endif
          begin
            state_d  = RUN;
            cnt_d    = '0;
            is_div_d = is_div_op(op_i);
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            dz_d     = is_div_op(op_i) && (b_i == '0);
            acc_hi_d = '0;
            opnd_d   = is_div_op(op_i) ? b_mag : a_mag;
            acc_lo_d = is_div_op(op_i) ? a_mag : b_mag;
          end
        end else begin
          if (hi_we_i) hi_d = wdata_i;
          if (lo_we_i) lo_d = wdata_i;
        end
      end
      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
